reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sequences the active-high reset lines that drive the design's async-reset D flip-flops (clear on `reset` high, capture `d` on `clk` rise). It holds every downstream reset domain asserted for a minimum stretch, then releases the domains one at a time in fixed order with a programmable gap. Software can re-run the sequence at any time through a request input. It sits between the top-level reset/control logic and the reset pins of each flop group.

## Interface
Parameters:
- `CHANNELS`, 4: number of downstream reset domains (1..16).
- `STRETCH`, 8: cycles all domains stay asserted before channel 0 releases (2..255).
- `GAP_W`, 4: width of the `gap` input.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous, active-low reset of this block.
- `req`  input  1  restart request, sampled each edge; level-sensitive.
- `gap`  input  GAP_W  extra cycles between successive channel releases.
- `reset_out`  output  CHANNELS  active-high resets to downstream async-reset flops; bit i drives domain i.
- `busy`  output  1  high while any `reset_out` bit is asserted.
- `done`  output  1  one-cycle pulse when the last channel releases.

## Operation
- All outputs come directly from flops. No combinational path from any input to `reset_out`.
- States: HOLD, RELEASE, RUN. Internal regs: `c` (cycle counter, at least 8 bits), `idx` (next channel to release), `gap_q` (latched gap).
- Reset (`rst_n` low at an edge): state=HOLD, `reset_out`=all ones, `busy`=1, `done`=0, `c`=0, `idx`=0, `gap_q`=`gap`. Reset overrides `req`.
- HOLD: if `c`==STRETCH-1, clear `reset_out[0]`, set `c`=0 and `idx`=1, and go to RELEASE. If CHANNELS==1, go straight to RUN with the RUN-entry actions below. Otherwise `c`++.
- RELEASE: if `c`==`gap_q`, clear `reset_out[idx]`, set `c`=0, `idx`++. If that was channel CHANNELS-1, go to RUN. Otherwise `c`++.
- RUN entry: on the same edge, `busy`=0 and `done`=1. `done` returns to 0 on the next edge.
- RUN: outputs hold. `req` high re-enters HOLD.
- Restart: `req` sampled high in any state with `rst_n` high does the following on that edge: `reset_out`=all ones, `busy`=1, `done`=0, `c`=0, `idx`=0, `gap_q`=`gap`, state=HOLD.
- While `req` stays high, the block stays in HOLD with `c` held at 0. Counting starts on the first edge after `req` is sampled low.
- `reset_out` bits release strictly in ascending index order. A released bit stays low until reset or restart.
- `gap_q` is frozen from HOLD entry until the next HOLD entry. Changes on `gap` mid-sequence have no effect.
- `gap`=0: channels release on consecutive edges.

## Timing
- Edge 1 is the first rising edge with `rst_n` sampled high, and `req` is low throughout.
- Channel i falls at edge STRETCH + i·(`gap_q`+1).
- `busy` falls and `done` rises at edge STRETCH + (CHANNELS-1)·(`gap_q`+1). `done` falls one edge later.
- Restart at edge R, with `req` low from R+1: `reset_out` is all ones from R. Channel 0 falls at R+STRETCH, channel i at R+STRETCH+i·(`gap_q`+1).
- Simultaneous events:
  - `req` on the edge that would release the last channel: restart wins, no `done` pulse.
  - `req` on the edge where `done` is high: `done` clears and the restart proceeds.
- Reset mid-sequence: identical to power-on reset. All channels reassert at that edge and the timing counts again from the edge where `rst_n` is sampled high.
- Minimum assertion width of every `reset_out` bit is STRETCH cycles.

## Test plan
- Power-on, defaults, `gap`=3: `reset_out` = 4'b1111 through edge 7. Bits 0..3 fall at edges 8, 12, 16, 20. `busy` falls at 20. `done` is high for exactly edge 20→21.
- `gap`=0: bits fall at edges 8, 9, 10, 11. `done` pulses at 11. `gap` changed to 7 at edge 9 leaves this timing unchanged.
- Restart from RUN: `req` is a one-cycle pulse sampled at edge R=40 with `gap`=1. `reset_out`=4'b1111 and `busy`=1 at 40. Bits fall at 48, 50, 52, 54.
- Restart mid-RELEASE: `req` pulse at edge 13 (bits 0,1 already low). All bits are high at 13, and bit 0 falls next at 21. `req` held high for edges 13..17 gives bit 0 falling at 25.
- `req` coincident with last release (edge 20, `gap`=3): no `done` pulse, `reset_out`=4'b1111, bit 0 falls at 28.
- `rst_n` low for one edge at edge 14, with `req` also high: all bits high and `busy`=1 at 14, `done` stays 0. Bits fall at 22, 26, 30, 34.

Source files
------------

// File: rtl/reset_sequencer.sv
// Holds all downstream reset domains asserted for STRETCH cycles, then releases
// them one at a time in ascending order with a programmable gap between releases.
module reset_sequencer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned STRETCH  = 8,
    parameter int unsigned GAP_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic [GAP_W-1:0]    gap,
    output logic [CHANNELS-1:0] reset_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CW = (GAP_W > 8) ? GAP_W : 8;
    localparam int unsigned IW = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       c_q, c_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [CHANNELS-1:0] reset_d;
    logic                busy_d;
    logic                done_d;

    // State register; every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HOLD;
            c_q       <= '0;
            idx_q     <= '0;
            gap_q     <= gap;
            reset_out <= '1;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            reset_out <= reset_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and next-output logic; a restart request overrides every state.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        reset_d = reset_out;
        busy_d  = busy;
        done_d  = 1'b0;

        if (req) begin
            state_d = HOLD;
            c_d     = '0;
            idx_d   = '0;
            gap_d   = gap;
            reset_d = '1;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (c_q == CW'(STRETCH - 1)) begin
                        reset_d[0] = 1'b0;
                        c_d        = '0;
                        idx_d      = IW'(1);
                        if (CHANNELS == 1) begin
                            state_d = RUN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (c_q == CW'(gap_q)) begin
                        reset_d = reset_out & ~(CHANNELS'(1) << idx_q);
                        c_d     = '0;
                        idx_d   = idx_q + IW'(1);
                        if (idx_q == IW'(CHANNELS - 1)) begin
                            state_d = RUN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: absolute release edges per scenario are hand-computed.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [3:0] gap;
    logic [3:0] reset_out;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;
    int ed;

    reset_sequencer #(
        .CHANNELS(4),
        .STRETCH (8),
        .GAP_W   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gap      (gap),
        .reset_out(reset_out),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ed, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ed++;
    endtask

    // Step up to edge 'last', checking outputs against absolute fall edges f0..f3 and done edge.
    task automatic expect_to(input int last, input int f0, input int f1, input int f2,
                             input int f3, input int done_e);
        logic [3:0] exp_r;
        while (ed < last) begin
            tick();
            exp_r = {ed < f3, ed < f2, ed < f1, ed < f0};
            check("reset_out", 32'(reset_out), 32'(exp_r));
            check("busy", 32'(busy), 32'(ed < done_e));
            check("done", 32'(done), 32'(ed == done_e));
        end
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst_n = 1'b0;
        req   = 1'b0;
        gap   = g;
        tick();
        ed    = 0;
        rst_n = 1'b1;
        check("rst_reset_out", 32'(reset_out), 32'hF);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_done", 32'(done), 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ed      = 0;
        rst_n   = 1'b0;
        req     = 1'b0;
        gap     = 4'd0;

        // Power-on, gap=3
        do_reset(4'd3);
        expect_to(25, 8, 12, 16, 20, 20);

        // gap=0, gap changes mid-sequence, then restart from RUN at edge 40 with gap=1
        do_reset(4'd0);
        expect_to(8, 8, 9, 10, 11, 11);
        gap = 4'd7;
        expect_to(39, 8, 9, 10, 11, 11);
        req = 1'b1;
        gap = 4'd1;
        expect_to(40, 48, 50, 52, 54, 54);
        req = 1'b0;
        expect_to(56, 48, 50, 52, 54, 54);

        // Restart mid-RELEASE, one-cycle pulse at edge 13
        do_reset(4'd3);
        expect_to(12, 8, 12, 16, 20, 20);
        req = 1'b1;
        expect_to(13, 21, 25, 29, 33, 33);
        req = 1'b0;
        expect_to(35, 21, 25, 29, 33, 33);

        // Restart held high for edges 13..17
        do_reset(4'd3);
        expect_to(12, 8, 12, 16, 20, 20);
        req = 1'b1;
        expect_to(17, 25, 29, 33, 37, 37);
        req = 1'b0;
        expect_to(39, 25, 29, 33, 37, 37);

        // Restart coincident with last release at edge 20
        do_reset(4'd3);
        expect_to(19, 8, 12, 16, 20, 20);
        req = 1'b1;
        expect_to(20, 28, 32, 36, 40, 40);
        req = 1'b0;
        expect_to(42, 28, 32, 36, 40, 40);

        // Reset mid-sequence at edge 14 with req also high
        do_reset(4'd3);
        expect_to(13, 8, 12, 16, 20, 20);
        rst_n = 1'b0;
        req   = 1'b1;
        expect_to(14, 22, 26, 30, 34, 34);
        rst_n = 1'b1;
        req   = 1'b0;
        expect_to(36, 22, 26, 30, 34, 34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
